// File: rtl/masked_share_decoder.sv
// masked_share_decoder
//
// Recombines a two-share Boolean-masked word back into plaintext
// (y = s0 ^ s1). Both shares are first refreshed with the same fresh random
// word m, then folded across separate register stages so that the two shares
// never meet in one combinational cone:
//   accept edge : t0 <= s0^m, t1 <= s1^m
//   HOLD edge   : acc <= t0, t0 <= 0
//   FOLD edge   : y <= acc^t1, acc <= 0, t1 <= 0, out_valid <= 1
//   OUT edge    : on out_ready, y <= 0, out_valid <= 0, dec_count++
// One word is in flight at a time; a word occupies four cycles minimum.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst        synchronous active-high reset, priority over everything
//   in_valid   share pair and random word present
//   in_ready   block can accept (IDLE only)
//   s0, s1     input shares (WIDTH)
//   m          fresh refresh randomness (WIDTH)
//   out_valid  plaintext valid
//   out_ready  downstream accepts plaintext
//   y          registered plaintext (WIDTH)
//   busy       high in any state other than IDLE
//   dec_count  completed output handshakes, wraps modulo 2^CNT_W
module masked_share_decoder #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] s0,
    input  logic [WIDTH-1:0] s1,
    input  logic [WIDTH-1:0] m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             busy,
    output logic [CNT_W-1:0] dec_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_FOLD = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [WIDTH-1:0] t0_reg;
    logic [WIDTH-1:0] t1_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] y_reg;
    logic             out_valid_reg;
    logic [CNT_W-1:0] dec_count_reg;

    // Refresh cones: each share is masked with m on its own, so s0 and s1
    // never share a combinational cone.
    logic [WIDTH-1:0] s0_ref;
    logic [WIDTH-1:0] s1_ref;
    // Final fold of refreshed share 0 (held in acc) with refreshed share 1.
    logic [WIDTH-1:0] fold;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign s0_ref[gi] = s0[gi] ^ m[gi];
            assign s1_ref[gi] = s1[gi] ^ m[gi];
            assign fold[gi]   = acc_reg[gi] ^ t1_reg[gi];
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (in_valid)  state_next = ST_HOLD;
            ST_HOLD:                state_next = ST_FOLD;
            ST_FOLD:                state_next = ST_OUT;
            ST_OUT:  if (out_ready) state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    // Output decode from the state register
    always_comb begin
        in_ready = (state_reg == ST_IDLE);
        busy     = (state_reg != ST_IDLE);
    end

    // Datapath: shares, accumulator, plaintext, counter.
    // Inputs are only looked at on the accepting edge, so X on s0/s1/m in
    // any other cycle never reaches a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            t0_reg        <= '0;
            t1_reg        <= '0;
            acc_reg       <= '0;
            y_reg         <= '0;
            out_valid_reg <= 1'b0;
            dec_count_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        t0_reg <= s0_ref;
                        t1_reg <= s1_ref;
                    end
                end
                ST_HOLD: begin
                    acc_reg <= t0_reg;
                    t0_reg  <= '0;
                end
                ST_FOLD: begin
                    y_reg         <= fold;
                    acc_reg       <= '0;
                    t1_reg        <= '0;
                    out_valid_reg <= 1'b1;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        y_reg         <= '0;
                        dec_count_reg <= dec_count_reg + 1'b1;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign y         = y_reg;
    assign out_valid = out_valid_reg;
    assign dec_count = dec_count_reg;

endmodule

// File: tb/tb_masked_share_decoder.sv
// Directed bench for masked_share_decoder. Two instances share all inputs:
// the default one (CNT_W=16) and a CNT_W=2 one for the counter-wrap check.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Timing follows the FSM: the accepting edge is the first of the four edges
// a word occupies, so out_valid rises after the second edge following accept.
module tb_masked_share_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready, in_ready2;
    logic [7:0] s0, s1, m;
    logic       out_valid, out_valid2;
    logic       out_ready;
    logic [7:0] y, y2;
    logic       busy, busy2;
    logic [15:0] dec_count;
    logic [1:0]  dec_count2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    masked_share_decoder #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .s0(s0), .s1(s1), .m(m), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .busy(busy), .dec_count(dec_count)
    );

    masked_share_decoder #(.WIDTH(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .s0(s0), .s1(s1), .m(m), .out_valid(out_valid2), .out_ready(out_ready),
        .y(y2), .busy(busy2), .dec_count(dec_count2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic [7:0] a, input logic [7:0] b, input logic [7:0] r);
        in_valid = 1'b1;
        s0 = a;
        s1 = b;
        m  = r;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        s0 = 'x;
        s1 = 'x;
        m  = 'x;
    endtask

    initial begin
        logic [7:0] m_tab [3];
        logic [7:0] t0_tab [3];
        logic [7:0] exp_y;
        int gap;

        m_tab  = '{8'h00, 8'hFF, 8'h6B};
        t0_tab = '{8'h12, 8'hED, 8'h79};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        s0 = 8'h00; s1 = 8'h00; m = 8'h00;
        tick(); tick();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", y, 8'h00);
        chk("rst_count", dec_count, 0);

        // ---- basic word: 0xA5 ^ 0x3C = 0x99 ----
        present(8'hA5, 8'h3C, 8'h5F);
        out_ready = 1'b1;
        tick();                       // accepting edge
        idle_inputs();
        chk("acc_in_ready", in_ready, 0);
        chk("acc_busy", busy, 1);
        chk("acc_out_valid", out_valid, 0);
        chk("acc_t0", dut.t0_reg, 8'hFA);
        chk("acc_t1", dut.t1_reg, 8'h63);
        tick();                       // HOLD edge
        chk("hold_t0_zero", dut.t0_reg, 8'h00);
        chk("hold_acc", dut.acc_reg, 8'hFA);
        chk("hold_out_valid", out_valid, 0);
        tick();                       // FOLD edge
        chk("fold_out_valid", out_valid, 1);
        chk("fold_y", y, 8'h99);
        chk("fold_in_ready", in_ready, 0);
        chk("fold_t0", dut.t0_reg, 8'h00);
        chk("fold_t1", dut.t1_reg, 8'h00);
        chk("fold_acc", dut.acc_reg, 8'h00);
        tick();                       // OUT edge with out_ready
        chk("done_out_valid", out_valid, 0);
        chk("done_y", y, 8'h00);
        chk("done_in_ready", in_ready, 1);
        chk("done_count", dec_count, 1);

        // ---- back-pressure ----
        out_ready = 1'b0;
        present(8'hA5, 8'h3C, 8'h5F);
        tick();
        idle_inputs();
        tick(); tick();
        chk("bp_rise_valid", out_valid, 1);
        chk("bp_rise_y", y, 8'h99);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) present(8'hFF, 8'h3C, 8'h5F);
            else        idle_inputs();
            tick();
            chk("bp_hold_y", y, 8'h99);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_in_ready", in_ready, 0);
            chk("bp_hold_count", dec_count, 1);
        end
        idle_inputs();
        out_ready = 1'b1;
        tick();
        chk("bp_done_valid", out_valid, 0);
        chk("bp_done_count", dec_count, 2);
        chk("bp_done_in_ready", in_ready, 1);
        tick();
        chk("bp_not_buffered", in_ready, 1);
        chk("bp_not_buffered_t0", dut.t0_reg, 8'h00);

        // ---- refresh independence: 0x12 ^ 0x34 = 0x26 ----
        for (int k = 0; k < 3; k++) begin
            present(8'h12, 8'h34, m_tab[k]);
            tick();
            idle_inputs();
            chk("ref_t0_hold", dut.t0_reg, t0_tab[k]);
            tick();
            chk("ref_t0_zero", dut.t0_reg, 8'h00);
            tick();
            chk("ref_y", y, 8'h26);
            chk("ref_zero_all", {dut.t0_reg, dut.t1_reg, dut.acc_reg}, 24'h0);
            tick();
            chk("ref_count", dec_count, 3 + k);
            chk("ref_idle_zero", {dut.t0_reg, dut.t1_reg, dut.acc_reg}, 24'h0);
        end

        // ---- reset while in FOLD ----
        present(8'h55, 8'hAA, 8'h0F);
        tick();
        idle_inputs();
        tick();                       // now in FOLD
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_y", y, 8'h00);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_count", dec_count, 0);
        chk("mid_rst_count2", dec_count2, 0);
        present(8'h01, 8'h02, 8'hC3);
        tick();
        idle_inputs();
        tick(); tick();
        chk("post_rst_y", y, 8'h03);
        chk("post_rst_valid", out_valid, 1);
        tick();
        chk("post_rst_count", dec_count, 1);

        // ---- reset together with out_ready in OUT ----
        present(8'h0A, 8'h0B, 8'h11);
        tick();
        idle_inputs();
        tick(); tick();               // now in OUT, out_ready=1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_vs_ready_count", dec_count, 0);
        chk("rst_vs_ready_valid", out_valid, 0);

        // ---- back-to-back words, counter wrap on the CNT_W=2 instance ----
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            present(8'(k * 8'h11), 8'h0F, 8'(8'h40 + k));
            exp_y = 8'(k * 8'h11) ^ 8'h0F;
            gap = 0;
            tick(); gap++;
            // in_valid stays high: must be ignored outside IDLE
            for (int j = 0; j < 2; j++) begin
                chk("b2b_in_ready_low", in_ready, 0);
                tick(); gap++;
            end
            chk("b2b_y", y, exp_y);
            tick(); gap++;
            chk("b2b_gap", gap, 4);
            chk("b2b_in_ready_rise", in_ready, 1);
            chk("b2b_count16", dec_count, k + 1);
            chk("b2b_count2", dec_count2, (k + 1) % 4);
        end
        idle_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
